// File: rtl/execute_stage_if.sv
// Decode <-> execute bus.
// The master side (decode, or a testbench) drives the decoded instruction:
// control flags, operands val1..val3 and the forwarding selects.
// The slave side (execute_stage) returns its registered results:
// ALU result, register write-back, memory request, branch redirect,
// halt status and the retired-instruction count.
interface execute_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  // Decoded instruction, driven by the master.
  logic              is_add;
  logic              is_sub;
  logic              is_and;
  logic              is_or;
  logic              is_gt;
  logic              is_eq;
  logic              is_branch;
  logic              is_mem_read;
  logic              is_mem_write;
  logic              is_reg_write;
  logic              is_halt;              // active low: 0 = halt instruction
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] val3;
  logic              is_val1_data_hazard;
  logic              is_val2_data_hazard;

  // Registered results, driven by the slave.
  logic [DATA_W-1:0] result;
  logic [3:0]        exe_reg_addr;
  logic              do_exe_reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              do_branch;
  logic [ADDR_W-1:0] branch_address;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  modport master (
    output is_add, is_sub, is_and, is_or, is_gt, is_eq, is_branch,
           is_mem_read, is_mem_write, is_reg_write, is_halt,
           val1, val2, val3, is_val1_data_hazard, is_val2_data_hazard,
    input  result, exe_reg_addr, do_exe_reg_write, mem_read, mem_write,
           mem_addr, mem_wdata, do_branch, branch_address, halted, retired
  );

  modport slave (
    input  is_add, is_sub, is_and, is_or, is_gt, is_eq, is_branch,
           is_mem_read, is_mem_write, is_reg_write, is_halt,
           val1, val2, val3, is_val1_data_hazard, is_val2_data_hazard,
    output result, exe_reg_addr, do_exe_reg_write, mem_read, mem_write,
           mem_addr, mem_wdata, do_branch, branch_address, halted, retired
  );
endinterface

// File: rtl/execute_stage.sv
// Execute pipeline stage.
// Takes one decoded instruction per cycle from the decode side of `bus` and
// registers its effect one cycle later: ALU result and write-back request,
// load/store request, taken-branch redirect, halt sequencing and a
// saturating count of retired instructions.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset; aborts anything in flight
//   bus  - execute_stage_if slave modport (decoded instruction in, results out)
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        exe_reg_addr_q, exe_reg_addr_d;
  logic              do_exe_reg_write_q, do_exe_reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              do_branch_q, do_branch_d;
  logic [ADDR_W-1:0] branch_address_q, branch_address_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [DATA_W-1:0] op_a, op_b;
  logic              is_alu, is_bubble, executes, taken;

  // Forwarding reads the result register as it stood before this edge.
  assign op_a = bus.is_val1_data_hazard ? result_q : bus.val1;
  assign op_b = bus.is_val2_data_hazard ? result_q : bus.val2;

  assign is_alu = bus.is_add | bus.is_sub | bus.is_and | bus.is_or;

  // The forwarding selects only modify operands, so they do not make an
  // otherwise empty slot into an instruction.
  assign is_bubble = bus.is_halt & ~(is_alu | bus.is_gt | bus.is_eq |
                     bus.is_branch | bus.is_mem_read | bus.is_mem_write |
                     bus.is_reg_write);

  // A slot right after a taken branch is wrong-path and is dropped.
  assign executes = (state_q == ST_RUN) & ~do_branch_q & ~is_bubble;

  assign taken = bus.is_branch &
                 ((bus.is_eq & (op_a == op_b)) |
                  (bus.is_gt & ($signed(op_a) > $signed(op_b))));

  always_comb begin
    // NOTE: every _d gets a default first (hold, or 0 for strobes) so no
    // path through the branches below can leave a latch behind.
    state_d            = state_q;
    result_d           = result_q;
    exe_reg_addr_d     = exe_reg_addr_q;
    do_exe_reg_write_d = 1'b0;
    mem_read_d         = 1'b0;
    mem_write_d        = 1'b0;
    mem_addr_d         = mem_addr_q;
    mem_wdata_d        = mem_wdata_q;
    do_branch_d        = 1'b0;
    branch_address_d   = branch_address_q;
    halted_d           = halted_q;
    retired_d          = retired_q;

    if (executes) begin
      if (retired_q != '1) begin
        retired_d = retired_q + CNT_W'(1);
      end

      if (!bus.is_halt) begin
        state_d = ST_DRAIN;
      end else begin
        if (bus.is_add)      result_d = op_a + op_b;
        else if (bus.is_sub) result_d = op_a - op_b;
        else if (bus.is_and) result_d = op_a & op_b;
        else if (bus.is_or)  result_d = op_a | op_b;

        if (is_alu | bus.is_mem_read | bus.is_reg_write) begin
          exe_reg_addr_d = bus.val3[3:0];
        end
        do_exe_reg_write_d = bus.is_reg_write & ~bus.is_mem_read;

        if (bus.is_mem_read) begin
          mem_read_d = 1'b1;
          mem_addr_d = ADDR_W'(op_a + op_b);
        end
        if (bus.is_mem_write) begin
          mem_write_d = 1'b1;
          mem_addr_d  = ADDR_W'(op_a + bus.val3);
          mem_wdata_d = op_b;
        end

        if (taken) begin
          do_branch_d      = 1'b1;
          branch_address_d = ADDR_W'(bus.val3);
        end
      end
    end

    // DRAIN gives the preceding memory/write-back op its cycle, then parks.
    if (state_q == ST_DRAIN) begin
      state_d  = ST_HALTED;
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    if (rst) begin
      state_q            <= ST_RUN;
      result_q           <= '0;
      exe_reg_addr_q     <= '0;
      do_exe_reg_write_q <= 1'b0;
      mem_read_q         <= 1'b0;
      mem_write_q        <= 1'b0;
      mem_addr_q         <= '0;
      mem_wdata_q        <= '0;
      do_branch_q        <= 1'b0;
      branch_address_q   <= '0;
      halted_q           <= 1'b0;
      retired_q          <= '0;
    end else begin
      state_q            <= state_d;
      result_q           <= result_d;
      exe_reg_addr_q     <= exe_reg_addr_d;
      do_exe_reg_write_q <= do_exe_reg_write_d;
      mem_read_q         <= mem_read_d;
      mem_write_q        <= mem_write_d;
      mem_addr_q         <= mem_addr_d;
      mem_wdata_q        <= mem_wdata_d;
      do_branch_q        <= do_branch_d;
      branch_address_q   <= branch_address_d;
      halted_q           <= halted_d;
      retired_q          <= retired_d;
    end
  end

  assign bus.result           = result_q;
  assign bus.exe_reg_addr     = exe_reg_addr_q;
  assign bus.do_exe_reg_write = do_exe_reg_write_q;
  assign bus.mem_read         = mem_read_q;
  assign bus.mem_write        = mem_write_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.do_branch        = do_branch_q;
  assign bus.branch_address   = branch_address_q;
  assign bus.halted           = halted_q;
  assign bus.retired          = retired_q;

endmodule
